// File: rtl/cmac_tx_control.sv
// cmac_tx_control: opens the user TX stream to the CMAC only while aligned and only at packet boundaries
module cmac_tx_control #(
  parameter int DATA_W        = 512,
  parameter int RESET_CYCLES  = 50,
  parameter int SETTLE_CYCLES = 1000,
  parameter int DRAIN_TIMEOUT = 256
) (
  input  logic                tx_clk,
  input  logic                sys_resetn_in,
  input  logic                rx_aligned,
  output logic                ctl_tx_enable,
  output logic                ctl_tx_send_rfi,
  output logic                reset_tx_datapath,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tuser,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                link_up,
  output logic [15:0]         drop_count
);
  typedef enum logic [2:0] {S_RESET, S_WAIT, S_UP, S_DRAIN, S_ABORT, S_FLUSH} state_t;
  localparam logic [15:0] RC = 16'(RESET_CYCLES);
  localparam logic [15:0] SC = 16'(SETTLE_CYCLES);
  localparam logic [15:0] DT = 16'(DRAIN_TIMEOUT);
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d, drop_q, drop_d;
  logic [3:0] sync_q;
  logic in_pkt_q, in_pkt_d, sync_al, open, abort, acc, acc_last;
  assign sync_al = sync_q[3];
  assign abort = state_q == S_ABORT;
  assign open = state_q == S_UP || (state_q == S_DRAIN && in_pkt_q);
  assign s_axis_tready = (state_q == S_FLUSH && in_pkt_q) || (open && m_axis_tready);
  assign m_axis_tvalid = abort || (open && s_axis_tvalid);
  assign m_axis_tdata = abort ? '0 : s_axis_tdata;
  assign m_axis_tkeep = abort ? '1 : s_axis_tkeep;
  assign m_axis_tlast = abort || s_axis_tlast;
  assign m_axis_tuser = abort;
  assign acc = s_axis_tvalid && s_axis_tready;
  assign acc_last = acc && s_axis_tlast;
  assign in_pkt_d = acc ? !s_axis_tlast : in_pkt_q;
  assign ctl_tx_enable = state_q inside {S_UP, S_DRAIN, S_ABORT};
  assign ctl_tx_send_rfi = state_q != S_UP;
  assign reset_tx_datapath = state_q == S_RESET;
  assign link_up = state_q == S_UP;
  assign drop_count = drop_q;
  always_ff @(posedge tx_clk or negedge sys_resetn_in)
    if (!sys_resetn_in) begin
      state_q <= S_RESET;
      cnt_q <= '0;
      drop_q <= '0;
      in_pkt_q <= 1'b0;
      sync_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      drop_q <= drop_d;
      in_pkt_q <= in_pkt_d;
      sync_q <= {sync_q[2:0], rx_aligned};
    end
  // one shared timer: reset hold, settle count, then drain/abort countdown
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    drop_d = drop_q;
    case (state_q)
      S_RESET: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == RC - 16'd1) begin
          state_d = S_WAIT;
          cnt_d = '0;
        end
      end
      S_WAIT: begin
        cnt_d = sync_al ? cnt_q + 16'd1 : '0;
        if (sync_al && cnt_d == SC) begin
          state_d = S_UP;
          cnt_d = '0;
        end
      end
      S_UP: if (!sync_al) begin
        state_d = (acc ? !s_axis_tlast : in_pkt_q) ? S_DRAIN : S_WAIT;
        cnt_d = state_d == S_DRAIN ? DT : '0;
      end
      S_DRAIN: begin
        cnt_d = cnt_q - 16'd1;
        if (acc_last || !in_pkt_q) begin
          state_d = S_WAIT;
          cnt_d = '0;
        end else if (cnt_q <= 16'd1) begin
          state_d = S_ABORT;
          cnt_d = DT;
        end
      end
      S_ABORT: begin
        cnt_d = cnt_q - 16'd1;
        if (m_axis_tready || cnt_q <= 16'd1) begin
          state_d = in_pkt_q ? S_FLUSH : S_WAIT;
          cnt_d = '0;
          drop_d = drop_q + {15'd0, drop_q != 16'hFFFF};
        end
      end
      S_FLUSH: if (acc_last || !in_pkt_q) state_d = S_WAIT;
      default: state_d = S_RESET;
    endcase
  end
endmodule

// File: tb/tb_cmac_tx_control.sv
// tb_cmac_tx_control: randomized scenario bench with an expected-beat scoreboard for cmac_tx_control
module tb_cmac_tx_control;
  localparam int DW = 512, KW = DW / 8, RC = 50, SC = 1000, DT = 256;
  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic l;
    logic u;
  } beat_t;
  logic clk = 1'b0, rst_n = 1'b0, rx_al = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic s_tlast = 1'b0, s_tvalid = 1'b0, m_tready = 1'b1;
  logic s_tready, m_tlast, m_tuser, m_tvalid, ctl_tx_enable, ctl_tx_send_rfi, reset_tx_datapath, link_up;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [15:0] drop_count;
  int n_chk = 0, n_fail = 0, exp_drop = 0;
  beat_t exp_q[$];
  beat_t mb;

  always #5 clk = ~clk;

  cmac_tx_control dut (
    .tx_clk(clk), .sys_resetn_in(rst_n), .rx_aligned(rx_al),
    .ctl_tx_enable(ctl_tx_enable), .ctl_tx_send_rfi(ctl_tx_send_rfi), .reset_tx_datapath(reset_tx_datapath),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .link_up(link_up), .drop_count(drop_count)
  );

  // every handshake on the CMAC side must match the next beat the model predicted
  always @(negedge clk) begin
    #2;
    if (rst_n && m_tvalid && m_tready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL m_beat: unexpected beat last=%b user=%b data=%h, required no beat", m_tlast, m_tuser, m_tdata[63:0]);
      end else begin
        mb = exp_q.pop_front();
        if ({m_tdata, m_tkeep, m_tlast, m_tuser} !== {mb.d, mb.k, mb.l, mb.u}) begin
          n_fail++;
          $display("FAIL m_beat: got last=%b user=%b keep=%h data=%h, required last=%b user=%b keep=%h data=%h",
                   m_tlast, m_tuser, m_tkeep, m_tdata[63:0], mb.l, mb.u, mb.k, mb.d[63:0]);
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic beat_t rnd_beat(input logic last);
    beat_t b;
    for (int i = 0; i < DW / 32; i++) b.d[i*32 +: 32] = $urandom();
    b.k = {$urandom(), $urandom()};
    b.l = last;
    b.u = 1'b0;
    return b;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_beat(input beat_t b, input bit pass, input bit rr);
    int t = 0;
    bit ok = 0;
    s_tdata = b.d;
    s_tkeep = b.k;
    s_tlast = b.l;
    s_tvalid = 1'b1;
    if (pass) exp_q.push_back(b);
    while (!ok && t < 50) begin
      if (rr) m_tready = $urandom_range(0, 3) != 0;
      #3;
      ok = s_tready;
      @(negedge clk);
      t++;
    end
    s_tvalid = 1'b0;
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL beat_accept: s_tready=%b after %0d cycles, required 1", s_tready, t);
    end
  endtask

  task automatic wait_up();
    int n = 0;
    rx_al = 1'b1;
    while (!link_up && n < 3000) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (!link_up) begin
      n_fail++;
      $display("FAIL link_up_timeout: link_up=%b after %0d cycles, required 1", link_up, n);
    end
  endtask

  task automatic check_wait_state(input string name);
    n_chk++;
    if ({ctl_tx_enable, ctl_tx_send_rfi, link_up, drop_count} !== {3'b010, 16'(exp_drop)} || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: en/rfi/up=%b%b%b drop=%0d pending=%0d, required 010 drop=%0d pending=0",
               name, ctl_tx_enable, ctl_tx_send_rfi, link_up, drop_count, exp_q.size(), exp_drop);
    end
  endtask

  task automatic test_reset();
    int n_rtd = 0, n_en = -1;
    logic prev_rfi = 1'b1;
    rst_n = 1'b0;
    rx_al = 1'b1;
    @(negedge clk);
    #2;
    n_chk++;
    if ({ctl_tx_enable, ctl_tx_send_rfi, reset_tx_datapath, s_tready, m_tvalid, link_up, drop_count} !== {6'b011000, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_values: en/rfi/rtd/srdy/mval/up=%b%b%b%b%b%b drop=%0d, required 011000 drop=0",
               ctl_tx_enable, ctl_tx_send_rfi, reset_tx_datapath, s_tready, m_tvalid, link_up, drop_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      if (reset_tx_datapath) n_rtd++;
      if (n_en < 0 && ctl_tx_enable) begin
        n_en = i;
        n_chk++;
        if ({prev_rfi, ctl_tx_send_rfi, link_up} !== 3'b101) begin
          n_fail++;
          $display("FAIL rfi_with_enable: prev_rfi/rfi/up=%b%b%b, required 101", prev_rfi, ctl_tx_send_rfi, link_up);
        end
      end
      prev_rfi = ctl_tx_send_rfi;
      @(negedge clk);
    end
    n_chk++;
    if (n_rtd != RC) begin
      n_fail++;
      $display("FAIL reset_hold: reset_tx_datapath high %0d cycles, required %0d", n_rtd, RC);
    end
    n_chk++;
    if (n_en < 0 || n_en - n_rtd < SC || n_en - n_rtd > SC + 5) begin
      n_fail++;
      $display("FAIL enable_delay: enable after %0d cycles past reset hold, required %0d..%0d", n_en - n_rtd, SC, SC + 5);
    end
  endtask

  task automatic test_passthrough();
    int len;
    for (int p = 0; p < 4; p++) begin
      len = $urandom_range(1, 6);
      for (int i = 1; i <= len; i++) begin
        send_beat(rnd_beat(i == len), 1, 1);
        cyc($urandom_range(0, 2));
      end
    end
    m_tready = 1'b1;
    cyc(2);
    n_chk++;
    if (exp_q.size() != 0 || !link_up || drop_count !== 16'(exp_drop)) begin
      n_fail++;
      $display("FAIL passthrough: pending=%0d up=%b drop=%0d, required pending=0 up=1 drop=%0d", exp_q.size(), link_up, drop_count, exp_drop);
    end
  endtask

  task automatic test_idle_loss();
    m_tready = 1'b1;
    rx_al = 1'b0;
    cyc(5);
    n_chk++;
    if ({s_tready, ctl_tx_enable, ctl_tx_send_rfi, link_up} !== 4'b0010) begin
      n_fail++;
      $display("FAIL idle_loss: srdy/en/rfi/up=%b%b%b%b, required 0010", s_tready, ctl_tx_enable, ctl_tx_send_rfi, link_up);
    end
    for (int i = 0; i < 5; i++) begin
      s_tdata = rnd_beat(1'b1).d;
      s_tlast = 1'b1;
      s_tvalid = 1'b1;
      #2;
      n_chk++;
      if ({s_tready, m_tvalid} !== 2'b00) begin
        n_fail++;
        $display("FAIL closed_gate: srdy/mval=%b%b, required 00", s_tready, m_tvalid);
      end
      @(negedge clk);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic test_settle_restart();
    int n = 0;
    rx_al = 1'b1;
    cyc(604);
    n_chk++;
    if (link_up !== 1'b0) begin
      n_fail++;
      $display("FAIL early_up: link_up=%b at settle 600, required 0", link_up);
    end
    rx_al = 1'b0;
    cyc(20);
    rx_al = 1'b1;
    while (!link_up && n < 1500) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (n < SC || n > SC + 10) begin
      n_fail++;
      $display("FAIL settle_restart: link_up after %0d cycles, required %0d..%0d", n, SC, SC + 10);
    end
  endtask

  task automatic test_drain();
    wait_up();
    m_tready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) rx_al = 1'b0;
      send_beat(rnd_beat(i == 10), 1, 0);
      if (i > 3 && i < 10) cyc($urandom_range(0, 3));
    end
    check_wait_state("drain_end");
  endtask

  task automatic test_abort();
    int d0 = -1, a0 = -1;
    beat_t ab;
    wait_up();
    m_tready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      if (i == 3) rx_al = 1'b0;
      send_beat(rnd_beat(1'b0), 1, 0);
    end
    ab.d = '0;
    ab.k = '1;
    ab.l = 1'b1;
    ab.u = 1'b1;
    exp_q.push_back(ab);
    for (int i = 0; i < 300; i++) begin
      if (d0 < 0 && ctl_tx_enable && ctl_tx_send_rfi) d0 = i;
      #2;
      if (a0 < 0 && m_tvalid && m_tuser) a0 = i;
      @(negedge clk);
    end
    exp_drop++;
    n_chk++;
    if (d0 < 0 || a0 < 0 || a0 - d0 != DT) begin
      n_fail++;
      $display("FAIL abort_timing: drain at %0d abort beat at %0d, required gap %0d", d0, a0, DT);
    end
    n_chk++;
    if (drop_count !== 16'(exp_drop)) begin
      n_fail++;
      $display("FAIL drop_count: got %0d, required %0d", drop_count, exp_drop);
    end
    for (int i = 6; i <= 10; i++) send_beat(rnd_beat(i == 10), 0, 0);
    check_wait_state("flush_end");
  endtask

  task automatic test_tlast_wins();
    wait_up();
    m_tready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) rx_al = 1'b0;
      send_beat(rnd_beat(1'b0), 1, 0);
    end
    cyc(DT + 3);
    send_beat(rnd_beat(1'b1), 1, 0);
    check_wait_state("tlast_at_expiry");
  endtask

  task automatic test_simul_loss();
    wait_up();
    m_tready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      if (i == 2) rx_al = 1'b0;
      send_beat(rnd_beat(i == 6), 1, 0);
    end
    check_wait_state("loss_with_tlast");
  endtask

  task automatic test_async_reset();
    int n_rtd = 0;
    wait_up();
    m_tready = 1'b1;
    for (int i = 1; i <= 2; i++) send_beat(rnd_beat(1'b0), 1, 0);
    m_tready = 1'b0;
    s_tdata = rnd_beat(1'b0).d;
    s_tlast = 1'b0;
    s_tvalid = 1'b1;
    #2;
    n_chk++;
    if ({m_tvalid, s_tready} !== 2'b10) begin
      n_fail++;
      $display("FAIL stalled_beat: mval/srdy=%b%b, required 10", m_tvalid, s_tready);
    end
    #1 rst_n = 1'b0;
    #1;
    exp_drop = 0;
    n_chk++;
    if ({ctl_tx_enable, ctl_tx_send_rfi, reset_tx_datapath, s_tready, m_tvalid, link_up, drop_count} !== {6'b011000, 16'd0}) begin
      n_fail++;
      $display("FAIL async_reset: en/rfi/rtd/srdy/mval/up=%b%b%b%b%b%b drop=%0d, required 011000 drop=0",
               ctl_tx_enable, ctl_tx_send_rfi, reset_tx_datapath, s_tready, m_tvalid, link_up, drop_count);
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (reset_tx_datapath) n_rtd++;
      @(negedge clk);
    end
    n_chk++;
    if (n_rtd != RC) begin
      n_fail++;
      $display("FAIL restart_hold: reset_tx_datapath high %0d cycles, required %0d", n_rtd, RC);
    end
    wait_up();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_idle_loss();
    test_settle_restart();
    test_drain();
    test_abort();
    test_tlast_wins();
    test_simul_loss();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
